multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multicycle MIPS main controller. Replaces the single-cycle opcode decoder with a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Sits between the instruction register opcode field and the shared-ALU/unified-memory datapath.
- Generalises the decoder in two ways: opcodes are parameters, and memory accesses use a ready handshake so wait states are supported.
- Adds addi, bne and j beyond R-format/lw/sw/beq.

Parameters:
- OP_W, 6, opcode field width
- OP_RTYPE, 6'h00, R-format opcode
- OP_LW, 6'h23, load word
- OP_SW, 6'h2B, store word
- OP_BEQ, 6'h04, branch if equal
- OP_BNE, 6'h05, branch if not equal
- OP_ADDI, 6'h08, add immediate
- OP_J, 6'h02, jump

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Op  in  OP_W  opcode from instruction register (IR[31:26])
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- PCWriteCondNe  out  1  PC load if ALU not Zero
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register-file write data from MDR
- RegDst  out  1  destination register is rd
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
- ALUOp  out  2  0 = add, 1 = subtract, 2 = funct-decoded
- PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- state_o  out  4  current state, for debug

Behaviour:
- Reset: synchronous; state <= IDLE. In IDLE all outputs are 0 and state_o = 0. IDLE -> FETCH unconditionally.
- Outputs are decoded combinationally from state. Write/enable outputs in memory states are additionally gated by mem_ready.
- Unlisted outputs are 0 in every state.
- FETCH (1):
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
  - IRWrite and PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE (2): ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut). Next state by Op:
  - R-format -> EXEC_R
  - lw or sw -> MEM_ADDR
  - addi -> EXEC_I
  - beq or bne -> BRANCH
  - j -> JUMP
  - anything else -> see Optional Feature
- EXEC_R (3): ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> WB_R.
- WB_R (4): RegDst=1, RegWrite=1, MemtoReg=0, instr_done=1 -> FETCH.
- MEM_ADDR (5): ALUSrcA=1, ALUSrcB=2, ALUOp=0 -> MEM_RD for lw, MEM_WR for sw. Op is stable because IR is held.
- MEM_RD (6): MemRead=1, IorD=1. Wait while mem_ready=0; go to WB_MEM when mem_ready=1.
- WB_MEM (7): RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 -> FETCH.
- MEM_WR (8):
  - MemWrite=1, IorD=1.
  - Wait while mem_ready=0.
  - When mem_ready=1: instr_done=1 -> FETCH.
  - MemWrite stays high across wait cycles; the write commits on the mem_ready cycle.
- EXEC_I (9): ALUSrcA=1, ALUSrcB=2, ALUOp=0 -> WB_I.
- WB_I (10): RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
- BRANCH (11): ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSource=1. PCWriteCond=1 for beq, PCWriteCondNe=1 for bne. instr_done=1 -> FETCH.
- JUMP (12): PCWrite=1, PCSource=2, instr_done=1 -> FETCH.
- Latency with mem_ready held at 1, counting from the first FETCH cycle:
  - R-format 4, lw 5, sw 4, addi 4, beq/bne 3, j 3.
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Reset asserted mid-instruction (including during a memory wait): the next state is IDLE, and no write enable is asserted in the reset-following cycle.
- At most one of PCWrite, PCWriteCond, PCWriteCondNe is high in any cycle.
- MemRead and MemWrite are never high together.

Optional Feature:
- Macro: MCU_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> TRAP (13).
  - TRAP drives all outputs 0 except output illegal_op=1, and holds until reset.
  - illegal_op is a port present only under this macro.
- Undefined: unknown opcode in DECODE -> FETCH with instr_done=1 in DECODE, i.e. executes as a 2-cycle NOP.

Decomposition:
- Package mcu_pkg holds:
  - state encoding constants (IDLE=0 .. TRAP=13)
  - ALUOp codes
  - ALUSrcB codes
  - PCSource codes
  - default opcode constants
- One natural sub-module: mcu_op_decode, the combinational Op -> {is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j, is_illegal} decoder, instantiated by the FSM.

Test Plan:
- Reset for 2 cycles, then release with mem_ready=1 -> 1 IDLE cycle with all outputs 0; FETCH next with MemRead=1, IRWrite=1, PCWrite=1.
- Op=6'h00, mem_ready=1 -> states 1,2,3,4. RegWrite=1 and RegDst=1 in cycle 4 only; instr_done pulses once.
- Op=6'h23 with mem_ready low for 3 cycles in MEM_RD:
  - MEM_RD lasts 4 cycles with MemRead=1, IorD=1.
  - WB_MEM follows with MemtoReg=1, RegWrite=1.
  - Total latency 8.
- Op=6'h2B, mem_ready=1 -> MemWrite high exactly 1 cycle, RegWrite never high, latency 4.
- Op=6'h05 then Op=6'h04 -> BRANCH asserts PCWriteCondNe=1 (PCWriteCond=0), then PCWriteCond=1 (PCWriteCondNe=0); ALUOp=1 and PCSource=1 in both.
- Op=6'h3F:
  - With MCU_ILLEGAL_TRAP_EN: enters state 13 with illegal_op=1, and stays for 10 cycles until reset.
  - Without it: returns to FETCH after DECODE.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, ALU/mux select codes, default opcodes.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_J     = 6'h02;

endpackage

// File: rtl/mcu_op_decode.sv
// Combinational opcode classifier; anything not matching a known opcode is flagged illegal.
module mcu_op_decode
  import mcu_pkg::*;
#(
  parameter int              OP_W     = 6,
  parameter logic [OP_W-1:0] OP_RTYPE = OPC_RTYPE,
  parameter logic [OP_W-1:0] OP_LW    = OPC_LW,
  parameter logic [OP_W-1:0] OP_SW    = OPC_SW,
  parameter logic [OP_W-1:0] OP_BEQ   = OPC_BEQ,
  parameter logic [OP_W-1:0] OP_BNE   = OPC_BNE,
  parameter logic [OP_W-1:0] OP_ADDI  = OPC_ADDI,
  parameter logic [OP_W-1:0] OP_J     = OPC_J
) (
  input  logic [OP_W-1:0] i_op,
  output logic            o_is_r,
  output logic            o_is_lw,
  output logic            o_is_sw,
  output logic            o_is_beq,
  output logic            o_is_bne,
  output logic            o_is_addi,
  output logic            o_is_j,
  output logic            o_is_illegal
);

  always_comb begin
    o_is_r       = (i_op == OP_RTYPE);
    o_is_lw      = (i_op == OP_LW);
    o_is_sw      = (i_op == OP_SW);
    o_is_beq     = (i_op == OP_BEQ);
    o_is_bne     = (i_op == OP_BNE);
    o_is_addi    = (i_op == OP_ADDI);
    o_is_j       = (i_op == OP_J);
    o_is_illegal = ~(o_is_r | o_is_lw | o_is_sw | o_is_beq | o_is_bne | o_is_addi | o_is_j);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main controller FSM with mem_ready wait states.
// Define MCU_ILLEGAL_TRAP_EN to trap unknown opcodes (adds illegal_op port); otherwise they run as a NOP.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int              OP_W     = 6,
  parameter logic [OP_W-1:0] OP_RTYPE = OPC_RTYPE,
  parameter logic [OP_W-1:0] OP_LW    = OPC_LW,
  parameter logic [OP_W-1:0] OP_SW    = OPC_SW,
  parameter logic [OP_W-1:0] OP_BEQ   = OPC_BEQ,
  parameter logic [OP_W-1:0] OP_BNE   = OPC_BNE,
  parameter logic [OP_W-1:0] OP_ADDI  = OPC_ADDI,
  parameter logic [OP_W-1:0] OP_J     = OPC_J
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] Op,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            PCWriteCondNe,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            instr_done,
`ifdef MCU_ILLEGAL_TRAP_EN
  output logic            illegal_op,
`endif
  output logic [3:0]      state_o
);

  state_t r_state;
  logic w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_addi, w_is_j, w_is_illegal;

  mcu_op_decode #(
    .OP_W(OP_W), .OP_RTYPE(OP_RTYPE), .OP_LW(OP_LW), .OP_SW(OP_SW),
    .OP_BEQ(OP_BEQ), .OP_BNE(OP_BNE), .OP_ADDI(OP_ADDI), .OP_J(OP_J)
  ) u_op_decode (
    .i_op(Op), .o_is_r(w_is_r), .o_is_lw(w_is_lw), .o_is_sw(w_is_sw),
    .o_is_beq(w_is_beq), .o_is_bne(w_is_bne), .o_is_addi(w_is_addi),
    .o_is_j(w_is_j), .o_is_illegal(w_is_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     r_state <= S_FETCH;
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_illegal)
`ifdef MCU_ILLEGAL_TRAP_EN
            r_state <= S_TRAP;
`else
            r_state <= S_FETCH;
`endif
          else if (w_is_r)              r_state <= S_EXEC_R;
          else if (w_is_lw || w_is_sw)  r_state <= S_MEM_ADDR;
          else if (w_is_addi)           r_state <= S_EXEC_I;
          else if (w_is_beq || w_is_bne) r_state <= S_BRANCH;
          else                          r_state <= S_JUMP;
        end
        S_EXEC_R:   r_state <= S_WB_R;
        S_MEM_ADDR: r_state <= w_is_lw ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) r_state <= S_WB_MEM;
        S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
        S_EXEC_I:   r_state <= S_WB_I;
        S_WB_R, S_WB_MEM, S_WB_I, S_BRANCH, S_JUMP: r_state <= S_FETCH;
`ifdef MCU_ILLEGAL_TRAP_EN
        S_TRAP:     r_state <= S_TRAP;
`endif
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Mealy terms only on mem_ready in FETCH and MEM_WR; everything else is pure state decode.
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_B;
    ALUOp         = ALUOP_ADD;
    PCSource      = PCSRC_ALU;
    instr_done    = 1'b0;
`ifdef MCU_ILLEGAL_TRAP_EN
    illegal_op    = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
`ifndef MCU_ILLEGAL_TRAP_EN
        instr_done = w_is_illegal;
`endif
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_WB_R: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_MEM: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_WB_I: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALUOP_SUB;
        PCSource      = PCSRC_ALUOUT;
        PCWriteCond   = w_is_beq;
        PCWriteCondNe = w_is_bne;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
      end
`ifdef MCU_ILLEGAL_TRAP_EN
      S_TRAP: illegal_op = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed cases plus random instruction streams
// with random mem_ready wait states, checked against a phase-list reference model.
module tb_multicycle_control_unit;

  logic       clk, reset, mem_ready;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_o;
`ifdef MCU_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done),
`ifdef MCU_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int st;
    bit rdy;
  } cyc_t;
  cyc_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] cur_vec();
    return {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};
  endfunction

  // Instruction class: 0 R, 1 lw, 2 sw, 3 addi, 4 beq/bne, 5 j, 6 unknown
  function automatic int cls(input logic [5:0] op);
    case (op)
      6'h00: return 0;
      6'h23: return 1;
      6'h2B: return 2;
      6'h08: return 3;
      6'h04, 6'h05: return 4;
      6'h02: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic int base_lat(input int c);
    case (c)
      0, 2, 3: return 4;
      1:       return 5;
      4, 5:    return 3;
      default: return 2;
    endcase
  endfunction

  // Expected control word for a given phase, straight from the state/output table.
  function automatic logic [17:0] exp_vec(input int st, input bit rdy, input logic [5:0] op, input bit last);
    logic pcw = 0, pcc = 0, pcn = 0, iord = 0, mr = 0, mw = 0, irw = 0;
    logic m2r = 0, rdst = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, aop = 0, pcs = 0;
    case (st)
      1:  begin mr = 1; sb = 2'd1; irw = rdy; pcw = rdy; end
      2:  sb = 2'd3;
      3:  begin sa = 1; aop = 2'd2; end
      4:  begin rdst = 1; rw = 1; end
      5, 9: begin sa = 1; sb = 2'd2; end
      6:  begin mr = 1; iord = 1; end
      7:  begin m2r = 1; rw = 1; end
      8:  begin mw = 1; iord = 1; end
      10: rw = 1;
      11: begin sa = 1; aop = 2'd1; pcs = 2'd1; pcc = (op == 6'h04); pcn = (op == 6'h05); end
      12: begin pcw = 1; pcs = 2'd2; end
      default: ;
    endcase
    return {pcw, pcc, pcn, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, aop, pcs, last};
  endfunction

  // Phase list of one instruction; rdy=0 entries are memory wait cycles.
  task automatic build(input logic [5:0] op, input int wf, input int wm);
    q.delete();
    repeat (wf) q.push_back('{1, 1'b0});
    q.push_back('{1, 1'b1});
    q.push_back('{2, 1'($urandom_range(0, 1))});
    case (cls(op))
      0: begin q.push_back('{3, 1'($urandom_range(0, 1))}); q.push_back('{4, 1'($urandom_range(0, 1))}); end
      1: begin
        q.push_back('{5, 1'($urandom_range(0, 1))});
        repeat (wm) q.push_back('{6, 1'b0});
        q.push_back('{6, 1'b1});
        q.push_back('{7, 1'($urandom_range(0, 1))});
      end
      2: begin
        q.push_back('{5, 1'($urandom_range(0, 1))});
        repeat (wm) q.push_back('{8, 1'b0});
        q.push_back('{8, 1'b1});
      end
      3: begin q.push_back('{9, 1'($urandom_range(0, 1))}); q.push_back('{10, 1'($urandom_range(0, 1))}); end
      4: q.push_back('{11, 1'($urandom_range(0, 1))});
      5: q.push_back('{12, 1'($urandom_range(0, 1))});
      default: ;
    endcase
  endtask

  // Starts aligned at the first FETCH cycle, ends aligned at the next one.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    int c = cls(op);
    int n = 0;
    int rw_cnt = 0;
    int mw_cnt = 0;
    bit seen = 0;
    int wmu = (c == 1 || c == 2) ? wm : 0;
    build(op, wf, wmu);
    Op = op;
    while (!seen && n < q.size() + 4) begin
      mem_ready = (n < q.size()) ? q[n].rdy : 1'b1;
      @(negedge clk);
      if (n < q.size()) begin
        chk("state", 32'(state_o), 32'(q[n].st));
        chk("ctl_word", 32'(cur_vec()), 32'(exp_vec(q[n].st, q[n].rdy, op, n == q.size() - 1)));
      end
      chk("pc_write_excl", 32'($countones({PCWrite, PCWriteCond, PCWriteCondNe}) <= 1), 32'd1);
      chk("mem_rw_excl", 32'(MemRead & MemWrite), 32'd0);
      rw_cnt += int'(RegWrite);
      mw_cnt += int'(MemWrite);
      seen = instr_done;
      n++;
      tick();
    end
    chk("latency", 32'(n), 32'(base_lat(c) + wf + wmu));
    chk("regwrite_cycles", 32'(rw_cnt), (c == 0 || c == 1 || c == 3) ? 32'd1 : 32'd0);
    chk("memwrite_cycles", 32'(mw_cnt), (c == 2) ? 32'(1 + wmu) : 32'd0);
  endtask

  // Two reset cycles, then checks the IDLE cycle; ends aligned at FETCH.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_state", 32'(state_o), 32'd0);
    chk("idle_outputs", 32'(cur_vec()), 32'd0);
`ifdef MCU_ILLEGAL_TRAP_EN
    chk("idle_illegal", 32'(illegal_op), 32'd0);
`endif
    tick();
  endtask

  logic [5:0] legal_ops[7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};

  initial begin
    Op = 6'h00;
    do_reset();

    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 0, 3);
    run_instr(6'h2B, 0, 0);
    run_instr(6'h05, 0, 0);
    run_instr(6'h04, 0, 0);
    run_instr(6'h08, 2, 0);
    run_instr(6'h02, 1, 0);
    run_instr(6'h2B, 1, 2);

    // Reset while lw waits in MEM_RD
    Op = 6'h23;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("wait_state", 32'(state_o), 32'd6);
    tick();
    @(negedge clk);
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_we", 32'({PCWrite, PCWriteCond, PCWriteCondNe, MemWrite, IRWrite, RegWrite}), 32'd0);
    reset = 1'b0;
    tick();
    run_instr(6'h00, 0, 0);

`ifdef MCU_ILLEGAL_TRAP_EN
    Op = 6'h3F;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("trap_fetch", 32'(state_o), 32'd1);
    tick();
    @(negedge clk);
    chk("trap_decode", 32'(state_o), 32'd2);
    chk("trap_decode_flag", 32'(illegal_op), 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trap_state", 32'(state_o), 32'd13);
      chk("trap_flag", 32'(illegal_op), 32'd1);
      chk("trap_outputs", 32'(cur_vec()), 32'd0);
      tick();
    end
    do_reset();
`else
    run_instr(6'h3F, 0, 0);
    run_instr(6'h11, 1, 0);
`endif

    for (int k = 0; k < 200; k++) begin
      logic [5:0] op;
      op = legal_ops[$urandom_range(0, 6)];
`ifndef MCU_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (cls(op) != 6);
      end
`endif
      run_instr(op, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0,
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
